// File: rtl/cc_screen_sequencer.sv
// Screen sequencer: drives the 3-way screen mux through IDLE -> CLEAR -> FILL -> PLAY on a divided tick.
// In PLAY an 8-bit LFSR produces one obstacle row per tick. Optional feature macro: SCREENSEQ_PAUSE_EN.
module cc_screen_sequencer #(
    parameter int         DATAWIDTH   = 8,
    parameter int         TICK_DIV    = 25000000,
    parameter int         CLEAR_TICKS = 2,
    parameter int         FILL_TICKS  = 2,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
    input  logic                 CC_SCREENSEQ_CLOCK_50,
    input  logic                 CC_SCREENSEQ_RESET_InHigh,
    input  logic                 CC_SCREENSEQ_start_InHigh,
    input  logic                 CC_SCREENSEQ_pause_InHigh,
    output logic [DATAWIDTH-1:0] CC_SCREENSEQ_select_OutBus,
    output logic [DATAWIDTH-1:0] CC_SCREENSEQ_data_OutBus,
    output logic                 CC_SCREENSEQ_rowvalid_OutHigh,
    output logic [1:0]           CC_SCREENSEQ_state_OutBus
);

    localparam int CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int MAX_TICKS = (CLEAR_TICKS > FILL_TICKS) ? CLEAR_TICKS : FILL_TICKS;
    localparam int NUM_W     = $clog2(MAX_TICKS + 1);

    localparam logic [CNT_W-1:0]     TICK_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]     CNT_ONE    = CNT_W'(1);
    localparam logic [NUM_W-1:0]     CLEAR_LAST = NUM_W'(CLEAR_TICKS - 1);
    localparam logic [NUM_W-1:0]     FILL_LAST  = NUM_W'(FILL_TICKS - 1);
    localparam logic [NUM_W-1:0]     NUM_MAX    = NUM_W'(MAX_TICKS);
    localparam logic [NUM_W-1:0]     NUM_ONE    = NUM_W'(1);
    localparam logic [7:0]           SEED       = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    localparam logic [DATAWIDTH-1:0] SEL_BLANK  = '0;
    localparam logic [DATAWIDTH-1:0] SEL_FILL   = DATAWIDTH'(1);
    localparam logic [DATAWIDTH-1:0] SEL_ROW    = DATAWIDTH'(2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_FILL  = 2'd2,
        S_PLAY  = 2'd3
    } stateT;

    stateT                r_state;
    logic [CNT_W-1:0]     r_tickCnt;
    logic [NUM_W-1:0]     r_tickNum;
    logic [7:0]           r_lfsr;
    logic [DATAWIDTH-1:0] r_select;
    logic [DATAWIDTH-1:0] r_data;
    logic                 r_rowValid;

    logic                 w_pause;
    logic                 w_tick;
    logic                 w_advance;
    logic [7:0]           w_lfsrNext;

`ifdef SCREENSEQ_PAUSE_EN
    assign w_pause = CC_SCREENSEQ_pause_InHigh;
`else
    logic w_unusedPause;
    assign w_unusedPause = CC_SCREENSEQ_pause_InHigh;
    assign w_pause       = 1'b0;
`endif

    // The counter is held at 0 in IDLE, so a tick can only occur once the sequence is running.
    assign w_tick     = (r_tickCnt == TICK_LAST);
    assign w_advance  = w_tick && !w_pause && (r_state != S_IDLE);
    assign w_lfsrNext = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};

    always_ff @(posedge CC_SCREENSEQ_CLOCK_50 or posedge CC_SCREENSEQ_RESET_InHigh) begin
        if (CC_SCREENSEQ_RESET_InHigh) begin
            r_state    <= S_IDLE;
            r_tickCnt  <= '0;
            r_tickNum  <= '0;
            r_lfsr     <= SEED;
            r_select   <= SEL_BLANK;
            r_data     <= '0;
            r_rowValid <= 1'b0;
        end else if (CC_SCREENSEQ_start_InHigh) begin
            // Restart from any state; a coinciding tick is dropped and the LFSR keeps its value.
            r_state    <= S_CLEAR;
            r_tickCnt  <= '0;
            r_tickNum  <= '0;
            r_select   <= SEL_BLANK;
            r_data     <= '0;
            r_rowValid <= 1'b0;
        end else begin
            r_rowValid <= 1'b0;
            if (r_state != S_IDLE && !w_pause) begin
                r_tickCnt <= w_tick ? '0 : r_tickCnt + CNT_ONE;
            end
            case (r_state)
                S_IDLE: begin
                    r_select <= SEL_BLANK;
                    r_data   <= '0;
                end
                S_CLEAR: begin
                    if (w_advance) begin
                        if (r_tickNum == CLEAR_LAST) begin
                            r_state   <= S_FILL;
                            r_tickNum <= '0;
                            r_select  <= SEL_FILL;
                        end else begin
                            r_tickNum <= r_tickNum + NUM_ONE;
                        end
                    end
                end
                S_FILL: begin
                    if (w_advance) begin
                        if (r_tickNum == FILL_LAST) begin
                            r_state    <= S_PLAY;
                            r_tickNum  <= '0;
                            r_select   <= SEL_ROW;
                            r_data     <= DATAWIDTH'(r_lfsr);
                            r_rowValid <= 1'b1;
                        end else begin
                            r_tickNum <= r_tickNum + NUM_ONE;
                        end
                    end
                end
                S_PLAY: begin
                    if (w_advance) begin
                        r_lfsr     <= w_lfsrNext;
                        r_data     <= DATAWIDTH'(w_lfsrNext);
                        r_rowValid <= 1'b1;
                        if (r_tickNum != NUM_MAX) begin
                            r_tickNum <= r_tickNum + NUM_ONE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign CC_SCREENSEQ_select_OutBus    = r_select;
    assign CC_SCREENSEQ_data_OutBus      = r_data;
    assign CC_SCREENSEQ_rowvalid_OutHigh = r_rowValid;
    assign CC_SCREENSEQ_state_OutBus     = r_state;

endmodule

// File: tb/tb_cc_screen_sequencer.sv
// Testbench for cc_screen_sequencer: directed scenarios followed by random start/pause/reset traffic,
// all compared against a cycle-count based reference model of the screen sequence.
module tb_cc_screen_sequencer;

    localparam int TD = 4;
    localparam int CT = 2;
    localparam int FT = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic [7:0] selectBus;
    logic [7:0] dataBus;
    logic       rowValid;
    logic [1:0] stateBus;

    int checkCount = 0;
    int passCount  = 0;

    // Reference model: phase, unpaused cycles spent in the phase, and position in the LFSR sequence.
    logic [7:0] lfsrSeq [255];
    int         mPhase;
    int         mAct;
    int         mIdx;
    int         mSel;
    logic [7:0] mData;
    logic       mValid;

    cc_screen_sequencer #(
        .DATAWIDTH  (8),
        .TICK_DIV   (TD),
        .CLEAR_TICKS(CT),
        .FILL_TICKS (FT),
        .LFSR_SEED  (8'hA5)
    ) dut (
        .CC_SCREENSEQ_CLOCK_50        (clock),
        .CC_SCREENSEQ_RESET_InHigh    (reset),
        .CC_SCREENSEQ_start_InHigh    (start),
        .CC_SCREENSEQ_pause_InHigh    (pause),
        .CC_SCREENSEQ_select_OutBus   (selectBus),
        .CC_SCREENSEQ_data_OutBus     (dataBus),
        .CC_SCREENSEQ_rowvalid_OutHigh(rowValid),
        .CC_SCREENSEQ_state_OutBus    (stateBus)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        mPhase = 0;
        mAct   = 0;
        mIdx   = 0;
        mSel   = 0;
        mData  = 8'h00;
        mValid = 1'b0;
    endtask

    task automatic modelStep(input logic s, input logic p);
        logic pauseEff;
`ifdef SCREENSEQ_PAUSE_EN
        pauseEff = p;
`else
        pauseEff = 1'b0;
`endif
        mValid = 1'b0;
        if (s) begin
            mPhase = 1;
            mAct   = 0;
            mSel   = 0;
            mData  = 8'h00;
        end else if (mPhase != 0 && !pauseEff) begin
            mAct++;
            if (mPhase == 1 && mAct == CT * TD) begin
                mPhase = 2;
                mAct   = 0;
                mSel   = 1;
            end else if (mPhase == 2 && mAct == FT * TD) begin
                mPhase = 3;
                mAct   = 0;
                mSel   = 2;
                mData  = lfsrSeq[mIdx];
                mValid = 1'b1;
            end else if (mPhase == 3 && mAct == TD) begin
                mAct   = 0;
                mIdx   = (mIdx + 1) % 255;
                mData  = lfsrSeq[mIdx];
                mValid = 1'b1;
            end
        end
    endtask

    task automatic checkModel();
        checkOutput("state", 32'(stateBus), 32'(mPhase));
        checkOutput("select", 32'(selectBus), 32'(mSel));
        checkOutput("data", 32'(dataBus), 32'(mData));
        checkOutput("rowvalid", 32'(rowValid), 32'(mValid));
    endtask

    task automatic applyStimulus(input logic s, input logic p);
        start = s;
        pause = p;
        @(posedge clock);
        modelStep(s, p);
        @(negedge clock);
        checkModel();
    endtask

    task automatic asyncReset();
        #2 reset = 1'b1;
        #1;
        checkOutput("asyncRstState", 32'(stateBus), 32'd0);
        checkOutput("asyncRstSelect", 32'(selectBus), 32'd0);
        checkOutput("asyncRstData", 32'(dataBus), 32'd0);
        checkOutput("asyncRstValid", 32'(rowValid), 32'd0);
        modelReset();
        start = 1'b0;
        pause = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic stepIdle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0);
    endtask

    task automatic expectRow(input string tag, input logic [7:0] row);
        checkOutput({tag, "State"}, 32'(stateBus), 32'd3);
        checkOutput({tag, "Data"}, 32'(dataBus), 32'(row));
        checkOutput({tag, "Valid"}, 32'(rowValid), 32'd1);
    endtask

    initial begin
        logic [7:0] v;
        int         pauseLeft;
        logic       rs;
        logic       rp;

        v = 8'hA5;
        for (int i = 0; i < 255; i++) begin
            lfsrSeq[i] = v;
            v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
        end
        modelReset();

        // Reset held for three cycles, then idle with start low
        repeat (3) @(negedge clock);
        checkModel();
        reset = 1'b0;
        stepIdle(5);

        // Start pulse walks through CLEAR and FILL into PLAY
        applyStimulus(1'b1, 1'b0);
        checkOutput("startToClear", 32'(stateBus), 32'd1);
        stepIdle(7);
        checkOutput("clearHeld", 32'(stateBus), 32'd1);
        stepIdle(1);
        checkOutput("fillState", 32'(stateBus), 32'd2);
        checkOutput("fillSelect", 32'(selectBus), 32'd1);
        stepIdle(8);
        expectRow("firstRow", 8'hA5);
        checkOutput("firstRowSelect", 32'(selectBus), 32'd2);
        stepIdle(1);
        checkOutput("pulseOneCycle", 32'(rowValid), 32'd0);
        stepIdle(3);
        expectRow("row4A", 8'h4A);
        stepIdle(4);
        expectRow("row95", 8'h95);
        stepIdle(4);
        expectRow("row2A", 8'h2A);

`ifdef SCREENSEQ_PAUSE_EN
        stepIdle(2);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, 1'b1);
            checkOutput("pausedValid", 32'(rowValid), 32'd0);
            checkOutput("pausedData", 32'(dataBus), 32'h2A);
        end
        stepIdle(1);
        checkOutput("releaseNoPulse", 32'(rowValid), 32'd0);
        stepIdle(1);
        expectRow("row54", 8'h54);
`else
        stepIdle(4);
        expectRow("row54", 8'h54);
`endif

        // Asynchronous reset mid-PLAY, then restart from the seed
        stepIdle(2);
        asyncReset();
        applyStimulus(1'b1, 1'b0);
        stepIdle(16);
        expectRow("seedAgain", 8'hA5);

        // Restart during PLAY keeps the LFSR value
        stepIdle(4);
        expectRow("againRow4A", 8'h4A);
        stepIdle(4);
        expectRow("againRow95", 8'h95);
        applyStimulus(1'b1, 1'b0);
        checkOutput("restartState", 32'(stateBus), 32'd1);
        checkOutput("restartData", 32'(dataBus), 32'd0);
        stepIdle(16);
        expectRow("retainedRow", 8'h95);
        stepIdle(4);
        expectRow("afterRetained", 8'h2A);

        // Random start, pause bursts and asynchronous resets
        pauseLeft = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                asyncReset();
            end else begin
                rs = ($urandom_range(0, 199) == 0) || (mPhase == 0 && $urandom_range(0, 19) == 0);
                if (pauseLeft == 0 && $urandom_range(0, 29) == 0) pauseLeft = $urandom_range(1, 12);
                rp = (pauseLeft != 0);
                if (pauseLeft != 0) pauseLeft--;
                applyStimulus(rs, rp);
            end
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
